cop_muldiv: RTL and testbench
=============================

Name: cop_muldiv

Overview:
- Multi-cycle multiply/divide coprocessor that executes the 3-bit operation code produced by the coprocessor-operation decoder.
- Holds the architectural HI/LO pair. LO alone serves MUL (rd writeback); HI/LO serve MULT, MADD, MSUBU and DIV.
- Sits beside the ALU; the core stalls on busy and samples hi/lo when done pulses.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request strobe; op/a/b are valid in the same cycle
- op  input  3  000 signed multiply (MULT/MUL), 001 signed MADD, 010 unsigned MSUBU, 011 signed DIV, 111 none
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi/lo hold the new result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE. Reset overrides everything, including an operation in flight.
- FSM states: IDLE, CALC, FIX, DONE. busy=1 in CALC, FIX and DONE. done=1 only in DONE.
- IDLE:
  - On start=1 with op in {000,001,010,011}: latch op, a and b, compute operand magnitudes (signed ops) or raw values (MSUBU), clear the iteration counter, go to CALC.
  - start with op=111 or any other code: ignored; stay IDLE; hi/lo unchanged.
- CALC: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add on magnitudes into a 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder magnitudes.
  - Counter reaching WIDTH-1 moves to FIX.
- FIX (1 cycle): apply signs and accumulation, write hi/lo, go to DONE.
  - 000: {hi,lo} = signed a*b.
  - 001: {hi,lo} = {hi,lo} + signed a*b, modulo 2^(2*WIDTH).
  - 010: {hi,lo} = {hi,lo} - unsigned a*b, modulo 2^(2*WIDTH).
  - 011: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - MADD/MSUBU accumulate from the hi/lo values present at FIX.
- DONE (1 cycle): done=1; hi/lo show the new result in this same cycle; next state is IDLE.
- Latency: start sampled at edge 0 -> done high during cycle WIDTH+2 (34 for WIDTH=32). A new start is accepted in the cycle after DONE.
- start while busy: ignored. No queuing, no effect on the result in flight.
- Divide by zero: no trap. Result is lo=all ones, hi=a. Still takes full latency.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0.
- hi/lo change only at FIX or on reset. They are stable at all other times, including during CALC.
- Operand inputs a, b and op may change freely after the start cycle without affecting the result.

Test Plan:
- Reset, then MULT: start, op=000, a=FFFFFFFD, b=00000007 -> busy for 34 cycles; done pulses once at cycle 34 with hi=FFFFFFFF, lo=FFFFFFEB.
- MADD following that MULT: a=2, b=3 -> hi=FFFFFFFF, lo=FFFFFFF1 (-15).
- MSUBU borrow across halves: MULT a=00010000, b=00010000 gives hi=1, lo=0; then op=010, a=1, b=1 -> hi=00000000, lo=FFFFFFFF.
- DIV cases, each after the previous completes:
  - a=FFFFFFF9, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
  - a=5, b=0 -> lo=FFFFFFFF, hi=00000005.
  - a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- Ignored requests:
  - start with op=111 -> busy stays 0, hi/lo unchanged.
  - Second start during CALC -> ignored; only the first result appears, done pulses exactly once.
- Reset mid-operation: assert rst at cycle 10 of a MULT -> next cycle hi=lo=0, busy=0, done=0 and done never pulses; a start one cycle after rst deasserts completes normally.

Source files
------------

// File: rtl/cop_muldiv_if.sv
// Request/response bundle between the core and the multiply/divide coprocessor.
// The core drives start/op/a/b; the coprocessor answers with busy/done/hi/lo.
interface cop_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/cop_muldiv.sv
// Multi-cycle multiply/divide coprocessor owning the HI/LO pair.
// One product or quotient bit per cycle, then a single sign/accumulate fix-up cycle.
module cop_muldiv #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    cop_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mc_q;
    logic [2*WIDTH-1:0] p_q;
    logic               neg_a;
    logic               neg_b;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               accept;
    logic               last;
    logic               is_div;
    logic               in_signed;
    logic               in_div;
    logic               in_neg_a;
    logic               in_neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;
    logic [2*WIDTH-1:0] result;

    assign accept    = (state == IDLE) && bus.start && !bus.op[2];
    assign last      = (cnt == CW'(WIDTH - 1));
    assign is_div    = (op_q == 3'b011);
    assign in_signed = (bus.op != 3'b010);
    assign in_div    = (bus.op == 3'b011);
    assign in_neg_a  = in_signed && bus.a[WIDTH-1];
    assign in_neg_b  = in_signed && bus.b[WIDTH-1];
    assign mag_a     = in_neg_a ? -bus.a : bus.a;
    assign mag_b     = in_neg_b ? -bus.b : bus.b;

    // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        add_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                 + (p_q[0] ? {1'b0, mc_q} : '0);
        mul_step = {add_sum, p_q[WIDTH-1:1]};
        shifted  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        diff     = shifted - {1'b0, mc_q};
        if (!diff[WIDTH]) begin
            div_step = {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {shifted[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_s = (neg_a ^ neg_b) ? -p_q : p_q;
        q_mag  = p_q[WIDTH-1:0];
        r_mag  = p_q[2*WIDTH-1:WIDTH];
        q_s    = (neg_a ^ neg_b) ? -q_mag : q_mag;
        r_s    = neg_a ? -r_mag : r_mag;
        result = '0;
        unique case (op_q)
            3'b000:  result = prod_s;
            3'b001:  result = {hi_q, lo_q} + prod_s;
            3'b010:  result = {hi_q, lo_q} - p_q;
            // A zero divisor yields lo=all ones and hi=the raw dividend.
            default: result = (mc_q == '0) ? {a_q, {WIDTH{1'b1}}}
                                           : {r_s, q_s};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (last) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            a_q   <= '0;
            mc_q  <= '0;
            p_q   <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.op;
                        a_q   <= bus.a;
                        neg_a <= in_neg_a;
                        neg_b <= in_neg_b;
                        cnt   <= '0;
                        mc_q  <= in_div ? mag_b : mag_a;
                        p_q   <= {{WIDTH{1'b0}}, in_div ? mag_a : mag_b};
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    p_q <= is_div ? div_step : mul_step;
                end
                FIX: begin
                    {hi_q, lo_q} <= result;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_cop_muldiv.sv
// Bench for cop_muldiv: directed cases plus random ops against an arithmetic model.
// Expected HI/LO values are queued at issue time and checked on each done pulse.
module tb_cop_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cop_muldiv_if #(.WIDTH(W)) bus ();

    cop_muldiv #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          exp_cnt = 0;
    logic [63:0] sb_q[$];
    logic [63:0] m_acc = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] acc);
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0: return sp;
            3'd1: return acc + sp;
            3'd2: return acc - up;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no result",
                         bus.hi, bus.lo);
            end else begin
                chk("scoreboard", {bus.hi, bus.lo}, sb_q.pop_front());
            end
        end
    end

    // Called on a negedge while idle; returns on the negedge after DONE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit intrude);
        int n;
        bit busy_ok;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (!op[2]) begin
            m_acc = model(op, a, b, m_acc);
            sb_q.push_back(m_acc);
            exp_cnt++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (op[2]) begin
            repeat (3) begin
                chk("ignored_busy", 64'(bus.busy), 64'd0);
                @(negedge clk);
            end
            chk("ignored_hilo", {bus.hi, bus.lo}, m_acc);
            return;
        end
        n = 1;
        busy_ok = 1'b1;
        while (n <= 60 && bus.done !== 1'b1) begin
            busy_ok &= (bus.busy === 1'b1);
            bus.start = intrude && (n == 5);
            if (bus.start) bus.op = 3'($urandom_range(0, 3));
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        if (n > 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no done after %0d cycles required 34", n - 1);
            return;
        end
        chk("latency", 64'(n), 64'd34);
        chk("busy_during", 64'(busy_ok), 64'd1);
        @(negedge clk);
        chk("idle_after", {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          dc;
        int          sel;

        bus.start = 1'b0;
        bus.op    = 3'b111;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);

        run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        chk("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'b001, 32'd2, 32'd3, 1'b0);
        chk("madd_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(3'b000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        chk("mult_hi_const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
        run_op(3'b010, 32'd1, 32'd1, 1'b0);
        chk("msubu_borrow", {bus.hi, bus.lo}, 64'h0000_0000_FFFF_FFFF);
        run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b011, 32'd5, 32'd0, 1'b0);
        chk("div_zero", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(3'b111, 32'd9, 32'd9, 1'b0);

        dc = done_cnt;
        run_op(3'b000, 32'h0000_1234, 32'h0000_5678, 1'b1);
        chk("intrude_result", {bus.hi, bus.lo}, 64'h0000_0000_0626_0060);
        chk("intrude_one_done", 64'(done_cnt - dc), 64'd1);

        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'h7654_3210;
        bus.b     = 32'h0123_4567;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("midrst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        rst = 1'b0;
        m_acc = '0;
        dc = done_cnt;
        @(negedge clk);
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("after_rst_one_done", 64'(done_cnt - dc), 64'd1);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            rop = (sel < 3) ? 3'b000 : (sel < 5) ? 3'b001 :
                  (sel < 7) ? 3'b010 : (sel < 9) ? 3'b011 : 3'b111;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 5) == 0) rb = rb >> $urandom_range(8, 31);
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(negedge clk);
        chk("done_count", 64'(done_cnt), 64'(exp_cnt));
        chk("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
